imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Shares one single-port synchronous instruction BRAM between two requesters:
  - the CPU fetch stage (reads);
  - the UART bootloader write path (writes program words).
- Sits between the CPU fetch stage, the loader, and the imem BRAM.
- Memory read latency is 1 cycle: address is registered, data appears the next cycle.
- Arbitration is per cycle. Fetch has priority, bounded by a starvation counter that guarantees loader progress.

Parameters:
- ADDR_W, 30, word address width (byte address [31:2]).
- DATA_W, 32, instruction word width.
- STARVE_MAX, 4, consecutive denied loader cycles before the loader is forced a grant (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  CPU requests a fetch this cycle.
- fetch_addr  in  ADDR_W  CPU fetch word address.
- fetch_inst  out  DATA_W  fetched instruction; meaningful when fetch_valid=1.
- fetch_valid  out  1  registered; fetch_inst holds data for the fetch granted last cycle.
- fetch_stall  out  1  combinational; fetch denied this cycle, CPU must hold fetch_addr.
- ld_valid  in  1  loader write request.
- ld_addr  in  ADDR_W  loader word address.
- ld_data  in  DATA_W  loader write data.
- ld_ready  out  1  combinational; write accepted this cycle (transfer = ld_valid & ld_ready).
- mem_addr  out  ADDR_W  BRAM address.
- mem_we  out  1  BRAM write enable.
- mem_wdata  out  DATA_W  BRAM write data.
- mem_rdata  in  DATA_W  BRAM read data, valid 1 cycle after a read address.

Behaviour:
- States: IDLE, FETCH, LOAD. The state holds the grant chosen for the current cycle and is registered for observability.
- Grant decision each cycle (combinational):
  1. LOAD if ld_valid & (~fetch_en | starve_cnt==STARVE_MAX);
  2. else FETCH if fetch_en;
  3. else IDLE.
- FETCH cycle:
  - mem_addr=fetch_addr, mem_we=0, fetch_stall=0, ld_ready=0.
  - Next cycle: fetch_valid=1 and fetch_inst=mem_rdata.
- LOAD cycle:
  - mem_addr=ld_addr, mem_we=1, mem_wdata=ld_data, ld_ready=1.
  - fetch_stall=fetch_en.
  - Next cycle: fetch_valid=0.
- IDLE cycle:
  - mem_we=0, ld_ready=0, fetch_stall=0.
  - mem_addr holds its last value.
  - Next cycle: fetch_valid=0.
- fetch_inst is registered:
  - captures mem_rdata only in the cycle following a FETCH grant;
  - otherwise holds its value.
- starve_cnt (4-bit):
  - increments (saturating at STARVE_MAX) when ld_valid=1 and the grant is not LOAD;
  - clears on a LOAD grant or when ld_valid=0.
- Exactly one of mem_we, a read, or idle occurs per cycle. A simultaneous read and write is impossible.
- Read-after-write: a fetch of address A in cycle n+1 after a write to A in cycle n returns the new data.
- Back-to-back loads with fetch_en=0: one write per cycle, ld_ready=1 every cycle.
- Continuous fetch_en with continuous ld_valid:
  - STARVE_MAX fetch grants, then 1 load grant, repeating;
  - each load cycle asserts fetch_stall.
- Reset (async assert, sync deassert by the system):
  - state=IDLE, fetch_valid=0, fetch_inst=0 (NOP), starve_cnt=0, mem_addr=0, mem_we=0, mem_wdata=0.
  - A fetch in flight at reset is discarded; no fetch_valid follows reset.

Optional Feature:
- IMEM_WR_COUNT_EN, when defined:
  - adds output ld_count [15:0], reset 0;
  - increments on every accepted write (ld_valid & ld_ready);
  - saturates at 16'hFFFF;
  - lets software confirm the bootload length.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, fetch_en=1, addr 0..3 with BRAM preloaded 32'h3c1d1000, 32'h0c000003, ... -> fetch_valid rises 1 cycle after each grant; fetch_inst matches each word in order; fetch_stall=0 throughout.
- fetch_en=0, ld_valid=1 for 4 cycles, addr 0x10..0x13, data 0xA0..0xA3 -> ld_ready=1 and mem_we=1 all 4 cycles with matching mem_addr/mem_wdata; fetch_valid=0.
- fetch_en=1 and ld_valid=1 held for 10 cycles, STARVE_MAX=4 -> grant pattern F,F,F,F,L,F,F,F,F,L; fetch_stall=1 exactly in the L cycles.
- Write 0xDEADBEEF to addr 0x20, then fetch 0x20 the next cycle -> fetch_inst=0xDEADBEEF one cycle after the fetch grant.
- Assert rst_n=0 mid-fetch (grant cycle) -> outputs go to reset values immediately; no fetch_valid pulse after release.
- With IMEM_WR_COUNT_EN defined: 5 accepted writes with ld_valid held through a stall -> ld_count=5; without the macro the bench compiles without ld_count.

Source files
------------

// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
//
// Shares one single-port synchronous instruction BRAM between the CPU fetch
// stage (reads) and the UART bootloader (writes). The grant is decided every
// cycle. Fetch normally wins, but a loader that has been refused STARVE_MAX
// cycles in a row is granted the next cycle, so loading always progresses.
//
// Parameters:
//   ADDR_W     word address width (byte address [31:2])
//   DATA_W     instruction word width
//   STARVE_MAX refused loader cycles before a forced load grant (1..15)
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   fetch_en     CPU fetch request
//   fetch_addr   CPU fetch word address
//   fetch_inst   fetched instruction, meaningful while fetch_valid=1
//   fetch_valid  registered; data for the fetch granted last cycle
//   fetch_stall  combinational; fetch refused this cycle, hold fetch_addr
//   ld_valid     loader write request
//   ld_addr      loader word address
//   ld_data      loader write data
//   ld_ready     combinational; write accepted this cycle
//   mem_addr     BRAM address
//   mem_we       BRAM write enable
//   mem_wdata    BRAM write data
//   mem_rdata    BRAM read data, one cycle after the read address
//   ld_count     (IMEM_WR_COUNT_EN only) saturating count of accepted writes
//
// Optional feature macro: IMEM_WR_COUNT_EN adds the ld_count output.
// ---------------------------------------------------------------------------
module imem_arbiter #(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_inst,
  output logic              fetch_valid,
  output logic              fetch_stall,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef IMEM_WR_COUNT_EN
  ,
  output logic [15:0]       ld_count
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]        grant_s;
  logic [1:0]        state_r;
  logic [3:0]        starve_cnt_r;
  logic              fetch_valid_r;
  logic [DATA_W-1:0] inst_hold_r;
  logic [ADDR_W-1:0] addr_hold_r;
  logic [DATA_W-1:0] wdata_hold_r;

  // Grant for the current cycle. While reset is asserted nothing is granted,
  // so the combinational outputs show their reset values at once.
  always_comb begin
    grant_s = ST_IDLE;
    if (!rst_n) begin
      grant_s = ST_IDLE;
    end else if (ld_valid && (!fetch_en || (starve_cnt_r == STARVE_LIM))) begin
      grant_s = ST_LOAD;
    end else if (fetch_en) begin
      grant_s = ST_FETCH;
    end else begin
      grant_s = ST_IDLE;
    end
  end

  // BRAM port and handshake drive. An idle cycle re-presents the previous
  // address and write data so the BRAM inputs do not toggle needlessly.
  always_comb begin
    mem_addr    = addr_hold_r;
    mem_we      = 1'b0;
    mem_wdata   = wdata_hold_r;
    ld_ready    = 1'b0;
    fetch_stall = 1'b0;
    case (grant_s)
      ST_FETCH: begin
        mem_addr = fetch_addr;
      end
      ST_LOAD: begin
        mem_addr    = ld_addr;
        mem_we      = 1'b1;
        mem_wdata   = ld_data;
        ld_ready    = 1'b1;
        fetch_stall = fetch_en;
      end
      default: begin
        mem_addr = addr_hold_r;
      end
    endcase
  end

  // Grant history, fetch response flag, starvation counter and held BRAM
  // inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      fetch_valid_r <= 1'b0;
      starve_cnt_r  <= 4'd0;
      addr_hold_r   <= '0;
      wdata_hold_r  <= '0;
    end else begin
      state_r       <= grant_s;
      fetch_valid_r <= (grant_s == ST_FETCH);
      addr_hold_r   <= mem_addr;
      wdata_hold_r  <= mem_wdata;
      if ((grant_s == ST_LOAD) || !ld_valid) begin
        starve_cnt_r <= 4'd0;
      end else if (starve_cnt_r != STARVE_LIM) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end
  end

  // Instruction hold register: captures the BRAM word in the cycle after a
  // fetch grant so fetch_inst keeps it until the next fetch returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_hold_r <= '0;
    end else if (state_r == ST_FETCH) begin
      inst_hold_r <= mem_rdata;
    end else begin
      inst_hold_r <= inst_hold_r;
    end
  end

  // In the response cycle the BRAM output register already holds the word,
  // so it is forwarded directly; afterwards the captured copy is shown.
  always_comb begin
    fetch_valid = fetch_valid_r;
    if (state_r == ST_FETCH) begin
      fetch_inst = mem_rdata;
    end else begin
      fetch_inst = inst_hold_r;
    end
  end

`ifdef IMEM_WR_COUNT_EN
  logic [15:0] ld_count_r;

  // Saturating count of accepted loader writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_count_r <= 16'd0;
    end else if (ld_valid && ld_ready && (ld_count_r != 16'hFFFF)) begin
      ld_count_r <= ld_count_r + 16'd1;
    end else begin
      ld_count_r <= ld_count_r;
    end
  end

  assign ld_count = ld_count_r;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_arbiter
//
// Directed bench for imem_arbiter. A simple BRAM sits on the memory port.
// A behavioural model tracks memory contents, how long the loader has been
// waiting, and the expected fetch response, and is compared against the DUT
// on every falling edge. Literal expectations for fetched words, the grant
// pattern under contention and read-after-write data pin the model itself.
// ---------------------------------------------------------------------------
module tb_imem_arbiter;

  localparam int STARVE = 4;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [29:0] fetch_addr;
  logic [31:0] fetch_inst;
  logic        fetch_valid;
  logic        fetch_stall;
  logic        ld_valid;
  logic [29:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [29:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef IMEM_WR_COUNT_EN
  logic [15:0] ld_count;
`endif

  int checks = 0;
  int errors = 0;

  imem_arbiter #(.ADDR_W(30), .DATA_W(32), .STARVE_MAX(STARVE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_en   (fetch_en),
    .fetch_addr (fetch_addr),
    .fetch_inst (fetch_inst),
    .fetch_valid(fetch_valid),
    .fetch_stall(fetch_stall),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef IMEM_WR_COUNT_EN
    ,
    .ld_count   (ld_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port BRAM with registered read data.
  logic [31:0] bram [0:255];
  logic [31:0] bram_q;
  always @(posedge clk) begin
    if (mem_we) bram[mem_addr[7:0]] <= mem_wdata;
    bram_q <= bram[mem_addr[7:0]];
  end
  assign mem_rdata = bram_q;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] ref_mem [0:255];
  int          m_wait;     // consecutive cycles the loader has been refused
  bit          m_valid;    // a fetch response is due this cycle
  logic [31:0] m_inst;     // word fetch_inst must show
  logic [29:0] m_addr;     // last address driven to the BRAM
  int          m_ldcnt;

  always @(negedge clk) begin
    bit          load_ok;
    bit          fetch_ok;
    logic [29:0] exp_addr;
    if (!rst_n) begin
      chk("rst_fetch_valid", fetch_valid, 1'b0);
      chk("rst_fetch_inst", fetch_inst, 32'h0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 30'h0);
      chk("rst_fetch_stall", fetch_stall, 1'b0);
      chk("rst_ld_ready", ld_ready, 1'b0);
`ifdef IMEM_WR_COUNT_EN
      chk("rst_ld_count", ld_count, 16'h0);
`endif
      m_wait  = 0;
      m_valid = 1'b0;
      m_inst  = 32'h0;
      m_addr  = 30'h0;
      m_ldcnt = 0;
    end else begin
      load_ok  = ld_valid && (!fetch_en || (m_wait >= STARVE));
      fetch_ok = fetch_en && !load_ok;
      exp_addr = load_ok ? ld_addr : (fetch_ok ? fetch_addr : m_addr);
      chk("fetch_valid", fetch_valid, m_valid);
      chk("fetch_inst", fetch_inst, m_inst);
      chk("ld_ready", ld_ready, load_ok);
      chk("mem_we", mem_we, load_ok);
      chk("fetch_stall", fetch_stall, load_ok && fetch_en);
      chk("mem_addr", mem_addr, exp_addr);
      if (load_ok) chk("mem_wdata", mem_wdata, ld_data);
`ifdef IMEM_WR_COUNT_EN
      chk("ld_count", ld_count, m_ldcnt);
`endif
      if (load_ok) begin
        ref_mem[ld_addr[7:0]] = ld_data;
        if (m_ldcnt < 65535) m_ldcnt++;
      end
      m_valid = fetch_ok;
      if (fetch_ok) m_inst = ref_mem[fetch_addr[7:0]];
      if (ld_valid && !load_ok) m_wait = (m_wait < STARVE) ? m_wait + 1 : STARVE;
      else m_wait = 0;
      m_addr = exp_addr;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit fe, input logic [29:0] fa, input bit lv,
                     input logic [29:0] la, input logic [31:0] ldd);
    @(posedge clk);
    #1;
    fetch_en   = fe;
    fetch_addr = fa;
    ld_valid   = lv;
    ld_addr    = la;
    ld_data    = ldd;
  endtask

  logic [31:0] words [0:3];
  logic [31:0] got   [0:3];
  logic [9:0]  rdy_pat;
  logic [9:0]  stl_pat;
  int          n;
  int          wn;

  initial begin
    words[0] = 32'h3c1d1000;
    words[1] = 32'h0c000003;
    words[2] = 32'h00000013;
    words[3] = 32'h00100093;
    for (int i = 0; i < 256; i++) begin
      bram[i]    = 32'h1000_0000 + 32'(i);
      ref_mem[i] = 32'h1000_0000 + 32'(i);
    end
    for (int i = 0; i < 4; i++) begin
      bram[i]    = words[i];
      ref_mem[i] = words[i];
    end
    bram_q     = 32'h0;
    rst_n      = 1'b0;
    fetch_en   = 1'b0;
    fetch_addr = 30'h0;
    ld_valid   = 1'b0;
    ld_addr    = 30'h0;
    ld_data    = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Sequential fetches of the preloaded program.
    n = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(k < 4, 30'(k), 1'b0, 30'h0, 32'h0);
      @(negedge clk);
      chk("t1_stall", fetch_stall, 1'b0);
      if (fetch_valid) begin
        if (n < 4) got[n] = fetch_inst;
        n++;
      end
    end
    chk("t1_count", n, 4);
    for (int i = 0; i < 4; i++) chk("t1_word", got[i], words[i]);

    // Back-to-back loads with no fetch traffic.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 30'h0, 1'b1, 30'h10 + 30'(k), 32'hA0 + 32'(k));
      @(negedge clk);
      chk("t2_ready", ld_ready, 1'b1);
      chk("t2_addr", mem_addr, 30'h10 + 30'(k));
      chk("t2_data", mem_wdata, 32'hA0 + 32'(k));
    end
    cyc(1'b0, 30'h0, 1'b0, 30'h0, 32'h0);

    // Contention: loader forced in after STARVE refused cycles.
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 30'h30 + 30'(k), 1'b1, 30'h50, 32'h5A5A_0000);
      @(negedge clk);
      rdy_pat[k] = ld_ready;
      stl_pat[k] = fetch_stall;
    end
    chk("t3_grant_pattern", rdy_pat, 10'b1000010000);
    chk("t3_stall_pattern", stl_pat, 10'b1000010000);
    cyc(1'b0, 30'h0, 1'b0, 30'h0, 32'h0);

    // Read-after-write.
    cyc(1'b0, 30'h0, 1'b1, 30'h20, 32'hDEADBEEF);
    cyc(1'b1, 30'h20, 1'b0, 30'h0, 32'h0);
    cyc(1'b0, 30'h0, 1'b0, 30'h0, 32'h0);
    @(negedge clk);
    chk("t4_valid", fetch_valid, 1'b1);
    chk("t4_inst", fetch_inst, 32'hDEADBEEF);

    // Reset asserted during a fetch grant cycle.
    cyc(1'b1, 30'h1, 1'b0, 30'h0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_mem_addr", mem_addr, 30'h0);
    chk("t5_stall", fetch_stall, 1'b0);
    chk("t5_we", mem_we, 1'b0);
    chk("t5_valid", fetch_valid, 1'b0);
    chk("t5_inst", fetch_inst, 32'h0);
    fetch_en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_no_valid", fetch_valid, 1'b0);
    end

    // Five accepted writes with the loader held through a stall.
    wn = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(k < 3, 30'(k), 1'b1, 30'h40 + 30'(wn), 32'h100 + 32'(wn));
      @(negedge clk);
      if (ld_ready) wn++;
    end
    chk("t6_writes", wn, 5);
    cyc(1'b0, 30'h0, 1'b0, 30'h0, 32'h0);
    @(negedge clk);
`ifdef IMEM_WR_COUNT_EN
    chk("t6_ld_count", ld_count, 16'd5);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
